// File: rtl/regfile_sequencer.sv
// regfile_sequencer: read/exec/write sequencer driving an 8x8 register file.
// Define SEQ_STATUS_FLAGS_EN to build the zero/carry status flag registers.
module regfile_sequencer #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic [DW-1:0] in_imm,
  output logic          rf_r1,
  output logic          rf_r2,
  output logic [AW-1:0] rf_r1p,
  output logic [AW-1:0] rf_r2p,
  output logic          rf_w,
  output logic [AW-1:0] rf_wp,
  output logic [DW-1:0] rf_ip,
  input  logic [DW-1:0] rf_op1,
  input  logic [DW-1:0] rf_op2,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          zero,
  output logic          carry
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDI = 3'd5;
  localparam logic [2:0] OP_MOV = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [2:0]    r_op;
  logic [AW-1:0] r_r1p;
  logic [AW-1:0] r_r2p;
  logic [AW-1:0] r_wp;
  logic [DW-1:0] r_ip;
  logic [DW-1:0] r_result;
  logic          r_done;
  logic          w_alu_in;
  logic          w_rd_in;
  logic          w_alu;
  logic          w_nop;
  logic          w_acc;
  logic [DW-1:0] w_res;

  assign w_alu_in = (in_op < OP_LDI);
  assign w_rd_in  = w_alu_in || (in_op == OP_MOV);
  assign w_alu    = (r_op < OP_LDI);
  assign w_nop    = (r_op == OP_NOP);
  assign w_acc    = (r_state == S_IDLE) && in_valid;

  assign rf_r1p = r_r1p;
  assign rf_r2p = r_r2p;
  assign rf_wp  = r_wp;
  assign rf_ip  = r_ip;
  assign done   = r_done;
  assign result = r_result;

  always_comb begin
    w_res = rf_op1;
    unique case (1'b1)
      r_op == OP_ADD: w_res = rf_op1 + rf_op2;
      r_op == OP_SUB: w_res = rf_op1 - rf_op2;
      r_op == OP_AND: w_res = rf_op1 & rf_op2;
      r_op == OP_OR:  w_res = rf_op1 | rf_op2;
      r_op == OP_XOR: w_res = rf_op1 ^ rf_op2;
      default:        w_res = rf_op1;
    endcase
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    rf_r1    = 1'b0;
    rf_r2    = 1'b0;
    rf_w     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          w_next = w_rd_in ? S_READ : S_WRITE;
      end
      S_READ: begin
        rf_r1  = 1'b1;
        rf_r2  = w_alu;
        w_next = S_EXEC;
      end
      S_EXEC: w_next = S_WRITE;
      S_WRITE: begin
        rf_w   = !w_nop;
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_r1p    <= '0;
      r_r2p    <= '0;
      r_wp     <= '0;
      r_ip     <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_WRITE);
      // pointers load only for ops that use them, so idle ports hold
      if (w_acc) begin
        r_op <= in_op;
        if (w_rd_in)          r_r1p <= in_rs1;
        if (w_alu_in)         r_r2p <= in_rs2;
        if (in_op != OP_NOP)  r_wp  <= in_rd;
        if (in_op == OP_LDI)  r_ip  <= in_imm;
      end
      if (r_state == S_EXEC)
        r_ip <= w_res;
      if (r_state == S_WRITE && !w_nop)
        r_result <= r_ip;
    end
  end

`ifdef SEQ_STATUS_FLAGS_EN
  logic r_cy;
  logic r_zero;
  logic r_carry;
  logic w_cy;

  always_comb begin
    w_cy = 1'b0;
    if (r_op == OP_ADD)
      w_cy = (w_res < rf_op1);
    else if (r_op == OP_SUB)
      w_cy = (rf_op1 < rf_op2);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cy    <= 1'b0;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      if (w_acc && in_op == OP_LDI)
        r_cy <= 1'b0;
      if (r_state == S_EXEC)
        r_cy <= w_cy;
      if (r_state == S_WRITE && !w_nop) begin
        r_zero  <= (r_ip == '0);
        r_carry <= r_cy;
      end
    end
  end

  assign zero  = r_zero;
  assign carry = r_carry;
`else
  assign zero  = 1'b0;
  assign carry = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer: sequencer + behavioural register file,
// directed and random instructions checked against a reference model.
module tb_regfile_sequencer;

  localparam int DW = 8;
  localparam int AW = 3;

`ifdef SEQ_STATUS_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [AW-1:0] in_rd;
  logic [AW-1:0] in_rs1;
  logic [AW-1:0] in_rs2;
  logic [DW-1:0] in_imm;
  logic          rf_r1;
  logic          rf_r2;
  logic [AW-1:0] rf_r1p;
  logic [AW-1:0] rf_r2p;
  logic          rf_w;
  logic [AW-1:0] rf_wp;
  logic [DW-1:0] rf_ip;
  logic [DW-1:0] rf_op1;
  logic [DW-1:0] rf_op2;
  logic          done;
  logic [DW-1:0] result;
  logic          zero;
  logic          carry;

  always #5 clk = ~clk;

  regfile_sequencer #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm),
    .rf_r1(rf_r1), .rf_r2(rf_r2),
    .rf_r1p(rf_r1p), .rf_r2p(rf_r2p),
    .rf_w(rf_w), .rf_wp(rf_wp), .rf_ip(rf_ip),
    .rf_op1(rf_op1), .rf_op2(rf_op2),
    .done(done), .result(result),
    .zero(zero), .carry(carry)
  );

  // register file: registered reads, active-high reset via inverter
  logic [DW-1:0] rf_mem [8];
  logic          rf_rst;
  assign rf_rst = ~reset;

  always @(posedge clk or posedge rf_rst) begin
    if (rf_rst) begin
      rf_op1 <= '0;
      rf_op2 <= '0;
    end else begin
      if (rf_r1) rf_op1 <= rf_mem[rf_r1p];
      if (rf_r2) rf_op2 <= rf_mem[rf_r2p];
    end
  end

  always @(posedge clk)
    if (rf_w) rf_mem[rf_wp] <= rf_ip;

  int total = 0;
  int bad   = 0;
  int ref_mem [8];
  int ref_result = 0;
  int ref_zero   = 0;
  int ref_carry  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input int rd,
                       input int rs1, input int rs2,
                       input int imm, input int gap);
    int a, b, val, cy, wi, i, waited, exp_done;
    bit alu, rd_ops, r2seen, got_done;
    alu    = (op < 3'd5);
    rd_ops = alu || (op == 3'd6);
    a  = ref_mem[rs1];
    b  = ref_mem[rs2];
    cy = 0;
    case (op)
      3'd0: begin val = a + b; cy = (val > 255) ? 1 : 0; val = val % 256; end
      3'd1: begin val = (a - b + 256) % 256; cy = (a < b) ? 1 : 0; end
      3'd2: val = a & b;
      3'd3: val = a | b;
      3'd4: val = a ^ b;
      3'd5: val = imm;
      3'd6: val = a;
      default: val = 0;
    endcase
    repeat (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_op    = op;
    in_rd    = rd[AW-1:0];
    in_rs1   = rs1[AW-1:0];
    in_rs2   = rs2[AW-1:0];
    in_imm   = imm[DW-1:0];
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("ready_wait", waited, 0);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    wi = -1;
    r2seen = 1'b0;
    got_done = 1'b0;
    for (i = 0; i < 8; i++) begin
      if (i == 0) begin
        chk("done_clear", done, 0);
        if (rd_ops) begin
          chk("r1_en", rf_r1, 1);
          chk("r1p", rf_r1p, rs1);
        end
        if (alu) chk("r2p", rf_r2p, rs2);
      end
      if (rf_r2) r2seen = 1'b1;
      if (rf_w && wi < 0) begin
        wi = i;
        chk("wp", rf_wp, rd);
        chk("ip", rf_ip, val);
      end
      if (done) begin
        got_done = 1'b1;
        break;
      end
      // busy: junk on the inputs must be ignored
      in_valid = 1'b1;
      in_op    = 3'($urandom);
      in_rd    = 3'($urandom);
      in_rs1   = 3'($urandom);
      in_rs2   = 3'($urandom);
      in_imm   = 8'($urandom);
      @(negedge clk);
    end
    exp_done = rd_ops ? 3 : 1;
    chk("done_seen", got_done, 1);
    chk("done_idx", i, exp_done);
    chk("w_idx", wi, (op == 3'd7) ? -1 : exp_done - 1);
    chk("r2_use", r2seen, alu);
    if (op != 3'd7) begin
      ref_mem[rd] = val;
      ref_result  = val;
      if (FL) begin
        ref_zero  = (val == 0) ? 1 : 0;
        ref_carry = cy;
      end
    end
    chk("result", result, ref_result);
    chk("zero", zero, ref_zero);
    chk("carry", carry, ref_carry);
    chk("ready_done", in_ready, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) ref_mem[k] = 0;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_op    = '0;
    in_rd    = '0;
    in_rs1   = '0;
    in_rs2   = '0;
    in_imm   = '0;
    @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_r1", rf_r1, 0);
    chk("rst_r2", rf_r2, 0);
    chk("rst_w", rf_w, 0);
    chk("rst_ip", rf_ip, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {zero, carry}, 0);
    reset = 1'b1;
    @(negedge clk);

    issue(3'd5, 0, 0, 0, 10, 0);
    issue(3'd5, 1, 0, 0, 20, 0);
    issue(3'd0, 2, 0, 1, 0, 0);
    issue(3'd1, 3, 0, 1, 0, 0);
    issue(3'd5, 4, 0, 0, 200, 0);
    issue(3'd5, 5, 0, 0, 100, 0);
    issue(3'd0, 6, 4, 5, 0, 0);
    issue(3'd4, 7, 2, 2, 0, 0);
    issue(3'd6, 0, 6, 0, 0, 0);
    issue(3'd7, 0, 0, 0, 0, 0);

    // reset during EXEC of ADD r1=r0+r0
    in_valid = 1'b1;
    in_op    = 3'd0;
    in_rd    = 3'd1;
    in_rs1   = 3'd0;
    in_rs2   = 3'd0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_w", rf_w, 0);
    chk("mid_r", {rf_r1, rf_r2}, 0);
    chk("mid_ptr", {rf_r1p, rf_r2p, rf_wp}, 0);
    chk("mid_ip", rf_ip, 0);
    chk("mid_done", done, 0);
    chk("mid_result", result, 0);
    chk("mid_flags", {zero, carry}, 0);
    repeat (2) begin
      @(negedge clk);
      chk("mid_hold_w", rf_w, 0);
    end
    reset = 1'b1;
    ref_result = 0;
    ref_zero   = 0;
    ref_carry  = 0;
    @(negedge clk);
    chk("rel_ready", in_ready, 1);
    chk("rel_done", done, 0);
    chk("rel_r1", rf_mem[1], ref_mem[1]);

    for (int n = 0; n < 40; n++) begin
      issue(3'($urandom), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 255),
            ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 2));
    end
    @(negedge clk);
    for (int k = 0; k < 8; k++)
      chk("mem_final", rf_mem[k], ref_mem[k]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Initiator-side controller for the 8x8 dual-read/single-write register file.
- Accepts one instruction at a time over a valid/ready handshake and drives the file's r1/r2/r1p/r2p read controls and w/wp/ip write controls.
- Sequences each instruction as read operands, execute ALU op, write back to rd.
- Sits between an instruction source and the register file; the register file's op1/op2 come back in as rf_op1/rf_op2.

Parameters:
DW, 8, data width (register file word)
AW, 3, register pointer width (2**AW registers)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  instruction valid
in_ready  output  1  sequencer can accept (high only in IDLE)
in_op  input  3  opcode
in_rd  input  AW  destination register
in_rs1  input  AW  source 1
in_rs2  input  AW  source 2
in_imm  input  DW  immediate for LDI
rf_r1  output  1  read-port-1 enable
rf_r2  output  1  read-port-2 enable
rf_r1p  output  AW  read-port-1 pointer
rf_r2p  output  AW  read-port-2 pointer
rf_w  output  1  write enable
rf_wp  output  AW  write pointer
rf_ip  output  DW  write data
rf_op1  input  DW  register file read data 1 (registered in the file, valid one cycle after rf_r1)
rf_op2  input  DW  register file read data 2
done  output  1  one-cycle retire pulse
result  output  DW  last written value
zero  output  1  status flag (see Optional Feature)
carry  output  1  status flag (see Optional Feature)

Behaviour:
- Reset (reset=0, async): state=IDLE; all rf_* outputs, done, result, zero and carry = 0; latched instruction fields = 0.
- Opcodes:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR: read rs1 and rs2.
  - 101 LDI: rd<=imm, no reads.
  - 110 MOV: rd<=rs1, read port 1 only.
  - 111 NOP: no reads, no write.
- FSM states: IDLE, READ, EXEC, WRITE.
- IDLE:
  - in_ready=1.
  - On in_valid at clk edge, latch op/rd/rs1/rs2/imm.
  - Next state: READ for ALU/MOV; WRITE for LDI/NOP.
- READ (1 cycle):
  - rf_r1=1, rf_r1p=rs1.
  - rf_r2=1 and rf_r2p=rs2 for ALU ops only.
  - rf_w=0 throughout, so the file's same-pointer read suppression never triggers.
  - Next state: EXEC.
- EXEC (1 cycle):
  - rf_op1/rf_op2 are valid.
  - Compute a DW+1-bit result and register it in a result register.
  - ADD: carry = bit DW of the sum.
  - SUB: two's-complement wrap; carry = borrow (rs1 < rs2, unsigned).
  - AND/OR/XOR/MOV: carry=0.
  - Next state: WRITE.
- WRITE (1 cycle):
  - rf_w=1, rf_wp=rd, rf_ip = computed value (imm for LDI) for all ops except NOP; NOP keeps rf_w=0.
  - On the exit edge: result<=written value, done<=1, state<=IDLE.
- done is high for exactly one cycle, in the IDLE cycle following WRITE; in_ready is also high then, so back-to-back instructions are accepted.
- Latency from the accept edge to the write-sampling edge: ALU/MOV 3 edges; LDI 1 edge.
- Outside their active state, rf_r1/rf_r2/rf_w = 0. Pointers and data hold their last values.
- in_valid is ignored while in_ready=0; instruction fields are sampled only at the accept edge.
- Reset mid-operation: immediate return to IDLE. rf_w drops asynchronously; the in-flight instruction is dropped with no write and no done.
- result for NOP: unchanged.

Optional Feature:
- Macro SEQ_STATUS_FLAGS_EN.
- When defined:
  - zero<=(written value==0) and carry<=ALU carry/borrow, both updated on the WRITE exit edge.
  - For LDI/MOV, carry=0.
  - NOP leaves zero and carry unchanged.
- When undefined: zero and carry are tied to 0 and no flag registers are built.

Test Plan:
- Bench setup: the sequencer is connected to the existing register file model, with both reset inputs driven from the same net (register file via an inverter).
- LDI r0=10; LDI r1=20; ADD r2=r0+r1 -> rf_w with wp=2, ip=30 three edges after accept; done pulses once; result=30; carry=0.
- SUB r3=r0-r1 (10-20) -> ip=0xF6, carry=1, zero=0 (flags only with SEQ_STATUS_FLAGS_EN; else both 0).
- LDI r4=200, LDI r5=100, ADD r6=r4+r5 -> ip=0x2C, carry=1; with in_valid held high continuously, in_ready/done show no dead cycles beyond the 4-cycle ALU cadence.
- XOR r7=r2^r2 -> ip=0, zero=1; MOV r0=r6 -> rf_r2 stays 0, ip=0x2C; NOP -> rf_w never asserted, done one cycle after WRITE, result unchanged.
- Assert reset low during EXEC of ADD r1=r0+r0 -> rf_w never rises, all outputs 0 immediately; after release in_ready=1 and register file r1 still holds 20.
